hazard_ctrl_mc: RTL and testbench



---
 rtl/hazard_ctrl_mc.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage core: load-use stall, branch flush and
// multi-cycle multiply hold, plus a saturating stall-cycle counter.
module hazard_ctrl_mc #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic [REG_ADDR_W-1:0] rd_EXE,
    input  logic                  MemRead_EXE,
    input  logic                  MulOp_EXE,
    input  logic                  branch_taken_EXE,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_Write,
    output logic                  stall_sel,
    output logic                  EX_MEM_bubble,
    output logic                  mul_busy,
    output logic                  mul_done,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int unsigned CNT_BITS = 4;
    // Start cycle counts as the first hold, so BUSY needs MUL_LATENCY-2 more.
    localparam logic [CNT_BITS-1:0] CNT_INIT =
        (MUL_LATENCY >= 2) ? CNT_BITS'(MUL_LATENCY - 2) : '0;
    localparam bit MUL_MULTI = (MUL_LATENCY >= 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                load_use_c;
    logic                mul_hold_c;

    assign load_use_c = MemRead_EXE && (rd_EXE != '0) &&
                        ((use_rs1_ID && (rs1_ID == rd_EXE)) ||
                         (use_rs2_ID && (rs2_ID == rd_EXE)));

    // Next-state, multiply sequencing and pipeline control outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mul_hold_c    = 1'b0;
        mul_done      = 1'b0;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        stall_sel     = 1'b1;
        EX_MEM_bubble = 1'b0;
        mul_busy      = 1'b0;
        stall_d       = stall_q;

        case (state_q)
            IDLE: begin
                if (MulOp_EXE) begin
                    if (MUL_MULTI) begin
                        mul_hold_c = 1'b1;
                        cnt_d      = CNT_INIT;
                        state_d    = BUSY;
                    end else begin
                        mul_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mul_hold_c = 1'b1;
                    cnt_d      = cnt_q - CNT_BITS'(1);
                end else begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase

        if (!rst) begin
            mul_busy = (state_q == BUSY);
            // Hold beats flush; a flush kills the ID instruction so load-use is moot.
            if (mul_hold_c) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_bubble = 1'b1;
            end else if (branch_taken_EXE) begin
                IF_ID_flush = 1'b1;
                stall_sel   = 1'b0;
            end else if (load_use_c) begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                stall_sel   = 1'b0;
            end
            if (!PCWrite && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end else begin
            mul_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: three builds (latency 4, 1, 2) share stimulus.
module tb_hazard_ctrl_mc;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EXE;
    logic       use_rs1_ID, use_rs2_ID, MemRead_EXE, MulOp_EXE, branch_taken_EXE;

    logic       pcw4, ifw4, fl4, idex4, ss4, exb4, busy4, done4;
    logic       pcw1, ifw1, fl1, idex1, ss1, exb1, busy1, done1;
    logic       pcw2, ifw2, fl2, idex2, ss2, exb2, busy2, done2;
    logic [15:0] cnt4;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;
    logic [7:0]  ctrl4, ctrl1, ctrl2;

    int errors = 0;
    int checks = 0;

    // Packed view: {PCWrite, IF_ID_Write, IF_ID_flush, ID_EX_Write, stall_sel, EX_MEM_bubble, mul_busy, mul_done}
    assign ctrl4 = {pcw4, ifw4, fl4, idex4, ss4, exb4, busy4, done4};
    assign ctrl1 = {pcw1, ifw1, fl1, idex1, ss1, exb1, busy1, done1};
    assign ctrl2 = {pcw2, ifw2, fl2, idex2, ss2, exb2, busy2, done2};

    hazard_ctrl_mc #(.REG_ADDR_W(5), .MUL_LATENCY(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rd_EXE(rd_EXE),
        .MemRead_EXE(MemRead_EXE), .MulOp_EXE(MulOp_EXE), .branch_taken_EXE(branch_taken_EXE),
        .PCWrite(pcw4), .IF_ID_Write(ifw4), .IF_ID_flush(fl4), .ID_EX_Write(idex4),
        .stall_sel(ss4), .EX_MEM_bubble(exb4), .mul_busy(busy4), .mul_done(done4),
        .stall_cycles(cnt4));

    hazard_ctrl_mc #(.REG_ADDR_W(5), .MUL_LATENCY(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rd_EXE(rd_EXE),
        .MemRead_EXE(MemRead_EXE), .MulOp_EXE(MulOp_EXE), .branch_taken_EXE(branch_taken_EXE),
        .PCWrite(pcw1), .IF_ID_Write(ifw1), .IF_ID_flush(fl1), .ID_EX_Write(idex1),
        .stall_sel(ss1), .EX_MEM_bubble(exb1), .mul_busy(busy1), .mul_done(done1),
        .stall_cycles(cnt1));

    hazard_ctrl_mc #(.REG_ADDR_W(5), .MUL_LATENCY(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rd_EXE(rd_EXE),
        .MemRead_EXE(MemRead_EXE), .MulOp_EXE(MulOp_EXE), .branch_taken_EXE(branch_taken_EXE),
        .PCWrite(pcw2), .IF_ID_Write(ifw2), .IF_ID_flush(fl2), .ID_EX_Write(idex2),
        .stall_sel(ss2), .EX_MEM_bubble(exb2), .mul_busy(busy2), .mul_done(done2),
        .stall_cycles(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_ID = '0; rs2_ID = '0; rd_EXE = '0;
        use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;
        MemRead_EXE = 1'b0; MulOp_EXE = 1'b0; branch_taken_EXE = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        MulOp_EXE = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b1101_1000) begin errors++; $display("FAIL rst_ctrl4 got %b want %b", ctrl4, 8'b1101_1000); end
        checks++;
        if (ctrl1 !== 8'b1101_1000) begin errors++; $display("FAIL rst_ctrl1 got %b want %b", ctrl1, 8'b1101_1000); end
        tick();
        MulOp_EXE = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (cnt4 !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", cnt4); end
        checks++;
        if (ctrl4 !== 8'b1101_1000) begin errors++; $display("FAIL rst_idle got %b want %b", ctrl4, 8'b1101_1000); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        MemRead_EXE = 1'b1; rd_EXE = 5'd5; rs2_ID = 5'd5; use_rs2_ID = 1'b1;
        rs1_ID = 5'd3; use_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b0001_0000) begin errors++; $display("FAIL lu_ctrl got %b want %b", ctrl4, 8'b0001_0000); end
        tick();
        checks++;
        if (cnt4 !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", cnt4); end
        // rs1 match path
        idle_inputs();
        MemRead_EXE = 1'b1; rd_EXE = 5'd9; rs1_ID = 5'd9; use_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b0001_0000) begin errors++; $display("FAIL lu_rs1 got %b want %b", ctrl4, 8'b0001_0000); end
        tick();
        checks++;
        if (cnt4 !== 16'd2) begin errors++; $display("FAIL lu_cnt2 got %0d want 2", cnt4); end
    endtask

    task automatic test_x0_unused();
        idle_inputs();
        MemRead_EXE = 1'b1; rd_EXE = 5'd0; rs1_ID = 5'd0; use_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b1101_1000) begin errors++; $display("FAIL x0 got %b want %b", ctrl4, 8'b1101_1000); end
        tick();
        rd_EXE = 5'd7; rs1_ID = 5'd7; use_rs1_ID = 1'b0; rs2_ID = 5'd2; use_rs2_ID = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b1101_1000) begin errors++; $display("FAIL unused got %b want %b", ctrl4, 8'b1101_1000); end
        MemRead_EXE = 1'b0; rs1_ID = 5'd7; use_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b1101_1000) begin errors++; $display("FAIL noload got %b want %b", ctrl4, 8'b1101_1000); end
        tick();
        checks++;
        if (cnt4 !== 16'd2) begin errors++; $display("FAIL x0_cnt got %0d want 2", cnt4); end
    endtask

    task automatic test_mul_and_reset_busy();
        idle_inputs();
        do_reset();
        MulOp_EXE = 1'b1;
        #1;
        // cycle 0
        checks++;
        if (ctrl4 !== 8'b0000_1100) begin errors++; $display("FAIL mul4_c0 got %b want %b", ctrl4, 8'b0000_1100); end
        checks++;
        if (ctrl1 !== 8'b1101_1001) begin errors++; $display("FAIL mul1_c0 got %b want %b", ctrl1, 8'b1101_1001); end
        checks++;
        if (ctrl2 !== 8'b0000_1100) begin errors++; $display("FAIL mul2_c0 got %b want %b", ctrl2, 8'b0000_1100); end
        tick();
        // cycle 1
        checks++;
        if (ctrl4 !== 8'b0000_1110) begin errors++; $display("FAIL mul4_c1 got %b want %b", ctrl4, 8'b0000_1110); end
        checks++;
        if (ctrl2 !== 8'b1101_1011) begin errors++; $display("FAIL mul2_c1 got %b want %b", ctrl2, 8'b1101_1011); end
        checks++;
        if (ctrl1 !== 8'b1101_1001) begin errors++; $display("FAIL mul1_c1 got %b want %b", ctrl1, 8'b1101_1001); end
        tick();
        checks++;
        if (ctrl4 !== 8'b0000_1110) begin errors++; $display("FAIL mul4_c2 got %b want %b", ctrl4, 8'b0000_1110); end
        tick();
        checks++;
        if (ctrl4 !== 8'b1101_1011) begin errors++; $display("FAIL mul4_c3 got %b want %b", ctrl4, 8'b1101_1011); end
        checks++;
        if (cnt4 !== 16'd3) begin errors++; $display("FAIL mul4_cnt got %0d want 3", cnt4); end
        tick();
        // cycle 4: back-to-back multiply restarts
        checks++;
        if (ctrl4 !== 8'b0000_1100) begin errors++; $display("FAIL mul4_c4 got %b want %b", ctrl4, 8'b0000_1100); end
        tick();
        checks++;
        if (ctrl4 !== 8'b0000_1110) begin errors++; $display("FAIL mul4_c5 got %b want %b", ctrl4, 8'b0000_1110); end
        // reset in cycle 1 of BUSY
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b1101_1000) begin errors++; $display("FAIL rstbusy got %b want %b", ctrl4, 8'b1101_1000); end
        tick();
        rst = 1'b0;
        MulOp_EXE = 1'b0;
        #1;
        checks++;
        if (ctrl4 !== 8'b1101_1000) begin errors++; $display("FAIL rstbusy_idle got %b want %b", ctrl4, 8'b1101_1000); end
        checks++;
        if (cnt4 !== 16'd0) begin errors++; $display("FAIL rstbusy_cnt got %0d want 0", cnt4); end
    endtask

    task automatic test_flush();
        idle_inputs();
        do_reset();
        branch_taken_EXE = 1'b1;
        MemRead_EXE = 1'b1; rd_EXE = 5'd4; rs1_ID = 5'd4; use_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b1111_0000) begin errors++; $display("FAIL flush_lu got %b want %b", ctrl4, 8'b1111_0000); end
        tick();
        checks++;
        if (cnt4 !== 16'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", cnt4); end
        MemRead_EXE = 1'b0;
        MulOp_EXE = 1'b1;
        #1;
        checks++;
        if (ctrl4 !== 8'b0000_1100) begin errors++; $display("FAIL br_mul got %b want %b", ctrl4, 8'b0000_1100); end
        tick();
        idle_inputs();
        do_reset();
    endtask

    task automatic test_saturate();
        idle_inputs();
        do_reset();
        MemRead_EXE = 1'b1; rd_EXE = 5'd12; rs2_ID = 5'd12; use_rs2_ID = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if (cnt2 !== 2'((n > 3) ? 3 : n)) begin
                errors++; $display("FAIL sat2_%0d got %0d want %0d", n, cnt2, (n > 3) ? 3 : n);
            end
            checks++;
            if (cnt4 !== 16'(n)) begin errors++; $display("FAIL sat4_%0d got %0d want %0d", n, cnt4, n); end
        end
        idle_inputs();
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_x0_unused();
        test_mul_and_reset_busy();
        test_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
